// File: rtl/xfer_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xfer_controller: round-robin sequencer of single-beat datapath transfers    |
// | with a response-window check. Revision: 1.0                                |
// +----------------------------------------------------------------------------+
module xfer_controller #(
  parameter int DATA_W   = 8,
  parameter int N_REQ    = 2,
  parameter int RESP_MIN = 1,
  parameter int RESP_MAX = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           gnt,
  input  logic                       ready,
  output logic                       start,
  output logic                       valid_in,
  output logic [DATA_W-1:0]          data_in,
  input  logic                       valid_out,
  input  logic [DATA_W-1:0]          data_out,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [7:0]                 err_cnt
);

  localparam int ID_W = $clog2(N_REQ);
  localparam logic [4:0] C_RESP_MIN = 5'(RESP_MIN);
  localparam logic [4:0] C_RESP_MAX = 5'(RESP_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     win_q, win_d;
  logic [DATA_W-1:0]   payload_q, payload_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rerr_q, rerr_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic [2*N_REQ-1:0]  req_dbl;
  logic [N_REQ-1:0]    req_rot;
  logic                found;
  int                  off;
  int                  pick_sum;
  logic [ID_W-1:0]     pick;
  logic [DATA_W-1:0]   pick_data;
  logic [1:0]          err_inc;
  logic [8:0]          err_sum;

  // Rotate requests so index 0 is the current pointer; lowest set bit wins.
  always_comb begin
    req_dbl  = {req, req} >> ptr_q;
    req_rot  = req_dbl[N_REQ-1:0];
    found    = |req_rot;
    off      = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) off = i;
    end
    pick_sum = int'(ptr_q) + off;
    if (pick_sum >= N_REQ) pick_sum = pick_sum - N_REQ;
    pick      = ID_W'(pick_sum);
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == pick) pick_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    payload_d = payload_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    case (state_q)
      S_IDLE: begin
        if (ready && found) begin
          win_d     = pick;
          payload_d = pick_data;
          ptr_d     = (pick == ID_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
          state_d   = S_START;
        end
      end
      S_START: state_d = S_SEND;
      S_SEND: begin
        cnt_d   = 5'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (valid_out) begin
          // Window upper bound is implicit: WAIT is left at cnt == RESP_MAX.
          if (cnt_q < C_RESP_MIN) begin
            rerr_d  = 1'b1;
            rdata_d = '0;
          end else begin
            rerr_d  = 1'b0;
            rdata_d = data_out;
          end
          state_d = S_RESP;
        end else if (cnt_q == C_RESP_MAX) begin
          rerr_d  = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stray valid_out and an error pulse in the same cycle both count.
  always_comb begin
    err_inc   = 2'(valid_out && (state_q != S_WAIT)) + 2'((state_q == S_RESP) && rerr_q);
    err_sum   = {1'b0, err_cnt_q} + {7'b0, err_inc};
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      payload_q <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      payload_q <= payload_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign start    = (state_q == S_START);
  assign gnt      = start ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_q) : '0;
  assign valid_in = (state_q == S_SEND);
  assign data_in  = valid_in ? payload_q : '0;
  assign done     = (state_q == S_RESP) && !rerr_q;
  assign error    = (state_q == S_RESP) && rerr_q;
  assign rsp_id   = (state_q == S_RESP) ? win_q : '0;
  assign rsp_data = done ? rdata_q : '0;
  assign err_cnt  = err_cnt_q;

endmodule
`default_nettype wire

// File: doc/xfer_controller.md
Name: xfer_controller

Overview:
- Sequences single-beat transfers through the checked start/valid_in/valid_out datapath on behalf of N_REQ requesters.
- Arbitrates requesters round-robin and issues a one-cycle start, then one valid_in beat.
- Checks that valid_out returns inside a programmable window and reports done or error per transfer.
- Sits between requester logic and the datapath. Its outputs are the datapath's start, valid_in and data_in.

Parameters:
- DATA_W, 8: data width.
- N_REQ, 2: number of requesters, 2..8.
- RESP_MIN, 1: earliest legal valid_out, counted in cycles after the valid_in cycle; 1 <= RESP_MIN <= RESP_MAX.
- RESP_MAX, 3: latest legal valid_out, counted in cycles after the valid_in cycle; max 15.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request; held until gnt.
- req_data  in  N_REQ*DATA_W  per-requester payload; slice i belongs to requester i.
- gnt  out  N_REQ  one-hot grant pulse.
- ready  in  1  datapath can accept a transfer.
- start  out  1  one-cycle transfer start.
- valid_in  out  1  payload beat valid.
- data_in  out  DATA_W  payload to datapath.
- valid_out  in  1  datapath result valid.
- data_out  in  DATA_W  datapath result.
- done  out  1  one-cycle success pulse.
- error  out  1  one-cycle failure pulse.
- rsp_id  out  $clog2(N_REQ)  requester index of the completed transfer.
- rsp_data  out  DATA_W  captured data_out; 0 on error.
- err_cnt  out  8  saturating count of error pulses plus stray valid_out cycles.

Behaviour:
- Reset (async assert, sync release): state IDLE, round-robin pointer 0, err_cnt 0. All outputs 0, including gnt, start, valid_in, data_in, done, error, rsp_id and rsp_data. Reset at any point aborts an in-flight transfer silently, with no done or error pulse.
- FSM states: IDLE, START, SEND, WAIT, RESP. Each is registered, and outputs decode directly from state and registers.
- IDLE: at an edge with ready=1 and |req=1, select the first set req at index >= ptr, wrapping modulo N_REQ. Latch the winner index and its req_data slice, set ptr = (winner+1) mod N_REQ, and go to START. With ready=0 or no req, stay in IDLE.
- START: start=1 and gnt[winner]=1 for exactly one cycle, then go to SEND. A ready deassertion after acceptance is ignored.
- SEND: valid_in=1 and data_in=latched payload for one cycle. Load wait counter cnt=1 and go to WAIT. data_in returns to 0 outside SEND.
- WAIT: the first WAIT cycle is cnt=1, and cnt increments each cycle. Evaluate in priority order:
  - valid_out=1 with cnt < RESP_MIN: error.
  - valid_out=1 with RESP_MIN <= cnt <= RESP_MAX: success; capture data_out into rsp_data.
  - valid_out=0 with cnt == RESP_MAX: timeout error.
  - Otherwise stay in WAIT.
  - Each outcome goes to RESP.
- RESP: exactly one of done or error is 1 for one cycle, with rsp_id=winner. rsp_data is valid with done and is 0 with error. Then go to IDLE.
- Back-to-back transfers: a minimum of one IDLE cycle between transfers. A requester that keeps req asserted is re-arbitrated fairly.
- Latency: acceptance edge E. start at cycle E+1, valid_in at E+2, first WAIT at E+3. done occurs at E+3+k for valid_out at cnt=k. Timeout error occurs at E+4+RESP_MAX-1.
- err_cnt:
  - +1 per error pulse.
  - +1 per cycle with valid_out=1 while the state is not WAIT (stray valid_out).
  - A stray valid_out and an error pulse in the same cycle count +2.
  - Saturates at 255 and never wraps.
- Simultaneous requests: exactly one grant. Arbitration happens only in IDLE; req changes in other states are ignored.

Test Plan:
- Single transfer: req=01, req_data[0]=8'hAB, ready=1, valid_out at cnt=2 with data_out=8'hAB -> gnt=01 with start at E+1, valid_in/data_in=AB at E+2, done=1 with rsp_id=0 and rsp_data=AB at E+5.
- Fairness: req=11 held, ready=1, immediate valid_out at cnt=1 -> grants alternate 01,10,01,10 over 4 transfers.
- Timeout: RESP_MAX=3, valid_out never asserted -> error=1 at E+6, rsp_data=0, err_cnt=1.
- Early response: RESP_MIN=2, valid_out at cnt=1 -> error in the next cycle, no done, err_cnt increments.
- Backpressure and stray valid_out: ready=0 with req=01 -> no start for 10 cycles. A valid_out pulse in IDLE -> err_cnt+1. Raise ready -> transfer proceeds normally.
- Reset mid-WAIT: rst_n=0 during WAIT -> all outputs 0 immediately, no done or error. After release, a new req=10 is granted first, since ptr=0 and req[0]=0.
